// File: rtl/gpio_serial_loader_if.sv
// Configuration bus, transfer handshake and serial chain outputs of gpio_serial_loader.
// The master side drives writes and start; the slave side is the loader itself.
interface gpio_serial_loader_if #(
   parameter int PAD_CTRL_BITS = 13
);
   logic                     cfg_we;
   logic [5:0]               cfg_addr;
   logic [PAD_CTRL_BITS-1:0] cfg_wdata;
   logic [PAD_CTRL_BITS-1:0] cfg_rdata;
   logic                     start;
   logic                     busy;
   logic                     done;
   logic                     wr_err;
   logic                     chain_clk_en;
   logic                     chain_data;
   logic                     chain_load;

   modport master (
      output cfg_we, cfg_addr, cfg_wdata, start,
      input  cfg_rdata, busy, done, wr_err, chain_clk_en, chain_data, chain_load
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata, start,
      output cfg_rdata, busy, done, wr_err, chain_clk_en, chain_data, chain_load
   );
endinterface

// File: rtl/gpio_serial_loader.sv
// Holds one configuration word per GPIO and shifts all of them, MSB of the last word first,
// into a daisy chain of GPIO control blocks, followed by a 2-cycle load strobe.
module gpio_serial_loader #(
   parameter int                       NUM_GPIO      = 19,
   parameter int                       PAD_CTRL_BITS = 13,
   parameter logic [PAD_CTRL_BITS-1:0] DEFAULT_CFG   = 13'h0403
) (
   input logic                 serial_clock,
   input logic                 resetn,
   gpio_serial_loader_if.slave bus
);
   localparam int               TOTAL    = NUM_GPIO * PAD_CTRL_BITS;
   localparam int               IDX_W    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_LOAD  = 2'd2
   } state_t;

   state_t                   r_state;
   logic [IDX_W-1:0]         r_bit_idx;
   logic                     r_load_cnt;
   logic                     r_busy;
   logic                     r_done;
   logic                     r_wr_err;
   logic                     r_chain_data;
   logic                     r_chain_clk_en;
   logic                     r_chain_load;
   logic [PAD_CTRL_BITS-1:0] r_cfg [NUM_GPIO];

   logic [TOTAL-1:0]         w_flat;
   logic [PAD_CTRL_BITS-1:0] w_rdata;
   logic                     w_addr_ok;
   logic                     w_wr_ok;

   assign w_addr_ok = (int'(bus.cfg_addr) < NUM_GPIO);
   assign w_wr_ok   = bus.cfg_we && (r_state == S_IDLE) && w_addr_ok;

   always_comb begin
      w_flat = '0;
      for (int g = 0; g < NUM_GPIO; g++) begin
         w_flat[g*PAD_CTRL_BITS +: PAD_CTRL_BITS] = r_cfg[g];
      end
   end

   // Out-of-range addresses match no entry and therefore read back as zero.
   always_comb begin
      w_rdata = '0;
      for (int g = 0; g < NUM_GPIO; g++) begin
         if (bus.cfg_addr == 6'(g)) begin
            w_rdata = r_cfg[g];
         end
      end
   end

   assign bus.cfg_rdata    = w_rdata;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.wr_err       = r_wr_err;
   assign bus.chain_clk_en = r_chain_clk_en;
   assign bus.chain_data   = r_chain_data;
   assign bus.chain_load   = r_chain_load;

   always_ff @(posedge serial_clock or negedge resetn) begin
      if (!resetn) begin
         for (int g = 0; g < NUM_GPIO; g++) begin
            r_cfg[g] <= DEFAULT_CFG;
         end
      end else if (w_wr_ok) begin
         for (int g = 0; g < NUM_GPIO; g++) begin
            if (bus.cfg_addr == 6'(g)) begin
               r_cfg[g] <= bus.cfg_wdata;
            end
         end
      end
   end

   always_ff @(posedge serial_clock or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_bit_idx  <= '0;
         r_load_cnt <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_wr_err   <= 1'b0;
      end else begin
         r_wr_err <= bus.cfg_we && !w_wr_ok;
         r_done   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state   <= S_SHIFT;
                  r_bit_idx <= LAST_IDX;
                  r_busy    <= 1'b1;
               end
            end
            S_SHIFT: begin
               if (r_bit_idx == '0) begin
                  r_state    <= S_LOAD;
                  r_load_cnt <= 1'b0;
               end else begin
                  r_bit_idx <= r_bit_idx - IDX_W'(1);
               end
            end
            S_LOAD: begin
               if (r_load_cnt) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_load_cnt <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Chain outputs change on the falling edge so data and the gate enable are stable
   // half a cycle before every rising edge of the gated chain clock.
   always_ff @(negedge serial_clock or negedge resetn) begin
      if (!resetn) begin
         r_chain_data   <= 1'b0;
         r_chain_clk_en <= 1'b0;
         r_chain_load   <= 1'b0;
      end else begin
         r_chain_data   <= w_flat[r_bit_idx];
         r_chain_clk_en <= (r_state == S_SHIFT);
         r_chain_load   <= (r_state == S_LOAD);
      end
   end
endmodule
